// File: rtl/axi_lite_req_arbiter_pkg.sv
// Shared types and width constants for the AXI4-Lite request arbiter.
// Used by the arbiter top, its winner picker and the bus interface.
package axi_lite_arb_pkg;

    typedef enum logic [2:0] {
        A_IDLE,
        A_WADDR,
        A_WRESP,
        A_RADDR,
        A_RDATA
    } arb_state_t;

    localparam int ARB_ADDR_W = 4;
    localparam int ARB_DATA_W = 32;

    function automatic int idx_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_lite_req_arbiter_if.sv
// AXI4-Lite channel bundle between the arbiter (master) and the slave.
interface axi_lite_req_arbiter_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output AWADDR, AWVALID, input AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input BVALID, output BREADY,
        output ARADDR, ARVALID, input ARREADY,
        input RDATA, RVALID, output RREADY
    );

    modport slave (
        input AWADDR, AWVALID, output AWREADY,
        input WDATA, WSTRB, WVALID, output WREADY,
        output BVALID, input BREADY,
        input ARADDR, ARVALID, output ARREADY,
        output RDATA, RVALID, input RREADY
    );
endinterface

// File: rtl/axi_lite_req_arbiter_rr_pick.sv
// Combinational winner select: round-robin after 'last', or lowest index
// when ARB_FIXED_PRIO_EN is defined.
module axi_lite_rr_pick
    import axi_lite_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int IW = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IW-1:0]      last,
    output logic               any,
    output logic [IW-1:0]      idx,
    output logic [NUM_REQ-1:0] onehot
);

    always_comb begin
        any    = 1'b0;
        idx    = '0;
        onehot = '0;
`ifdef ARB_FIXED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                any = 1'b1;
                idx = IW'(i);
            end
        end
`else
        // Walk backwards so the first candidate after 'last' is written last.
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (eligible[(int'(last) + k) % NUM_REQ]) begin
                any = 1'b1;
                idx = IW'((int'(last) + k) % NUM_REQ);
            end
        end
`endif
        if (any) onehot = NUM_REQ'(1) << idx;
    end

endmodule

// File: rtl/axi_lite_req_arbiter.sv
// Shares one AXI4-Lite slave among NUM_REQ request/ack clients, one
// transaction at a time. ARB_FIXED_PRIO_EN selects fixed priority.
module axi_lite_req_arbiter
    import axi_lite_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = ARB_ADDR_W,
    parameter int DATA_WIDTH = ARB_DATA_W
) (
    input  logic                              ACLK,
    input  logic                              ARESETn,
    input  logic [NUM_REQ-1:0]                REQ,
    input  logic [NUM_REQ-1:0]                REQ_WE,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]     REQ_ADDR,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     REQ_WDATA,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   REQ_WSTRB,
    output logic [NUM_REQ-1:0]                REQ_ACK,
    output logic [DATA_WIDTH-1:0]             REQ_RDATA,
    axi_lite_req_arbiter_if.master            axi
);

    localparam int SW = DATA_WIDTH / 8;
    localparam int IW = idx_w(NUM_REQ);

    arb_state_t            state_q, state_d;
    logic [IW-1:0]         ptr_q;
    logic [NUM_REQ-1:0]    gnt_q;
    logic [NUM_REQ-1:0]    ack_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [SW-1:0]         wstrb_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  aw_done_q, w_done_q;

    logic [NUM_REQ-1:0]    eligible;
    logic                  pick_any;
    logic [IW-1:0]         pick_idx;
    logic [NUM_REQ-1:0]    pick_oh;
    logic                  aw_hs, w_hs;

    // A requester being acked this cycle is not re-granted on the same edge.
    assign eligible = REQ & ~ack_q;

    axi_lite_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .eligible (eligible),
        .last     (ptr_q),
        .any      (pick_any),
        .idx      (pick_idx),
        .onehot   (pick_oh)
    );

    assign aw_hs = axi.AWVALID & axi.AWREADY;
    assign w_hs  = axi.WVALID & axi.WREADY;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) state_q <= A_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            A_IDLE:
                if (pick_any)
                    state_d = REQ_WE[pick_idx] ? A_WADDR : A_RADDR;
            A_WADDR:
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs))
                    state_d = A_WRESP;
            A_WRESP:
                if (axi.BVALID) state_d = A_IDLE;
            A_RADDR:
                if (axi.ARREADY) state_d = A_RDATA;
            A_RDATA:
                if (axi.RVALID) state_d = A_IDLE;
            default:
                state_d = A_IDLE;
        endcase
    end

    always_comb begin
        axi.AWVALID = (state_q == A_WADDR) && !aw_done_q;
        axi.WVALID  = (state_q == A_WADDR) && !w_done_q;
        axi.BREADY  = (state_q == A_WRESP);
        axi.ARVALID = (state_q == A_RADDR);
        axi.RREADY  = (state_q == A_RDATA);
    end

    assign axi.AWADDR = addr_q;
    assign axi.ARADDR = addr_q;
    assign axi.WDATA  = wdata_q;
    assign axi.WSTRB  = wstrb_q;
    assign REQ_ACK    = ack_q;
    assign REQ_RDATA  = rdata_q;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            ptr_q     <= IW'(NUM_REQ - 1);
            gnt_q     <= '0;
            ack_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            ack_q <= '0;
            unique case (state_q)
                A_IDLE:
                    if (pick_any) begin
                        addr_q  <= REQ_ADDR[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        wdata_q <= REQ_WDATA[pick_idx*DATA_WIDTH +: DATA_WIDTH];
                        wstrb_q <= REQ_WSTRB[pick_idx*SW +: SW];
                        gnt_q   <= pick_oh;
                        ptr_q   <= pick_idx;
                    end
                A_WADDR: begin
                    if (aw_hs) aw_done_q <= 1'b1;
                    if (w_hs)  w_done_q  <= 1'b1;
                end
                A_WRESP: begin
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                    if (axi.BVALID) ack_q <= gnt_q;
                end
                A_RDATA:
                    if (axi.RVALID) begin
                        ack_q   <= gnt_q;
                        rdata_q <= axi.RDATA;
                    end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_req_arbiter.sv
// Bench for axi_lite_req_arbiter: delay-configurable AXI4-Lite slave,
// transaction-level arbitration/memory model and an ack scoreboard.
module tb_axi_lite_req_arbiter;

    localparam int N  = 2;
    localparam int AW = 4;
    localparam int DW = 32;

    typedef struct {
        bit         we;
        logic [3:0] addr;
        logic [31:0] data;
        logic [3:0] strb;
    } op_t;

    typedef struct {
        int          idx;
        bit          we;
        logic [31:0] rd;
    } exp_t;

    logic              ACLK = 1'b0;
    logic              ARESETn;
    logic [N-1:0]      REQ;
    logic [N-1:0]      REQ_WE;
    logic [N*AW-1:0]   REQ_ADDR;
    logic [N*DW-1:0]   REQ_WDATA;
    logic [N*DW/8-1:0] REQ_WSTRB;
    logic [N-1:0]      REQ_ACK;
    logic [DW-1:0]     REQ_RDATA;

    axi_lite_req_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    axi_lite_req_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .REQ       (REQ),
        .REQ_WE    (REQ_WE),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_WDATA (REQ_WDATA),
        .REQ_WSTRB (REQ_WSTRB),
        .REQ_ACK   (REQ_ACK),
        .REQ_RDATA (REQ_RDATA),
        .axi       (axi)
    );

    always #5 ACLK = ~ACLK;

    // Slave register file with programmable ready/response delays
    int aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
    logic [31:0] smem [4];
    logic        aw_got, w_got, r_pend;
    int          aw_cnt, w_cnt, ar_cnt, r_cnt;
    logic [3:0]  s_addr, s_raddr, s_wstrb;
    logic [31:0] s_wdata;

    assign axi.AWREADY = axi.AWVALID && !aw_got && (aw_cnt >= aw_dly);
    assign axi.WREADY  = axi.WVALID && !w_got && (w_cnt >= w_dly);
    assign axi.ARREADY = axi.ARVALID && !r_pend && !axi.RVALID
                         && (ar_cnt >= ar_dly);

    always @(posedge ACLK) begin
        if (!ARESETn) begin
            for (int i = 0; i < 4; i++) smem[i] <= '0;
            aw_got <= 0; w_got <= 0; r_pend <= 0;
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            axi.BVALID <= 0; axi.RVALID <= 0; axi.RDATA <= '0;
            s_addr <= '0; s_raddr <= '0; s_wstrb <= '0; s_wdata <= '0;
        end else begin
            if (axi.AWVALID && axi.AWREADY) begin
                aw_got <= 1; s_addr <= axi.AWADDR; aw_cnt <= 0;
            end else if (axi.AWVALID && !aw_got) aw_cnt <= aw_cnt + 1;
            if (axi.WVALID && axi.WREADY) begin
                w_got <= 1; s_wdata <= axi.WDATA; s_wstrb <= axi.WSTRB; w_cnt <= 0;
            end else if (axi.WVALID && !w_got) w_cnt <= w_cnt + 1;
            if (aw_got && w_got && !axi.BVALID) begin
                for (int b = 0; b < 4; b++)
                    if (s_wstrb[b]) smem[s_addr[3:2]][8*b +: 8] <= s_wdata[8*b +: 8];
                axi.BVALID <= 1;
            end
            if (axi.BVALID && axi.BREADY) begin
                axi.BVALID <= 0; aw_got <= 0; w_got <= 0;
            end
            if (axi.ARVALID && axi.ARREADY) begin
                r_pend <= 1; s_raddr <= axi.ARADDR; r_cnt <= 0; ar_cnt <= 0;
            end else if (axi.ARVALID) ar_cnt <= ar_cnt + 1;
            if (r_pend) begin
                if (r_cnt >= r_dly) begin
                    axi.RVALID <= 1; axi.RDATA <= smem[s_raddr[3:2]]; r_pend <= 0;
                end else r_cnt <= r_cnt + 1;
            end
            if (axi.RVALID && axi.RREADY) axi.RVALID <= 0;
        end
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: memory contents and arbitration rule
    logic [31:0] mmem [4];
    int          m_last;
    exp_t        expq [$];
    op_t         bq [N][$];

    function automatic int mpick(logic [N-1:0] el, int last);
`ifdef ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (el[i]) return i;
`else
        for (int k = 1; k <= N; k++) if (el[(last + k) % N]) return (last + k) % N;
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_last = N - 1;
        for (int i = 0; i < 4; i++) mmem[i] = '0;
    endtask

    // Predict service order of a batch where every requester keeps REQ high
    // until its list is exhausted; a just-acked requester sits out one round.
    task automatic model_batch();
        int mp[N];
        int ja = -1;
        int w;
        logic [N-1:0] el;
        op_t o;
        exp_t e;
        for (int i = 0; i < N; i++) mp[i] = 0;
        forever begin
            el = '0;
            for (int i = 0; i < N; i++) el[i] = (mp[i] < bq[i].size());
            if (el == '0) break;
            if (ja >= 0 && (el & ~(N'(1) << ja)) != '0) el[ja] = 1'b0;
            w = mpick(el, m_last);
            o = bq[w][mp[w]];
            e.idx = w; e.we = o.we; e.rd = '0;
            if (o.we) begin
                for (int b = 0; b < 4; b++)
                    if (o.strb[b]) mmem[o.addr[3:2]][8*b +: 8] = o.data[8*b +: 8];
            end else e.rd = mmem[o.addr[3:2]];
            expq.push_back(e);
            mp[w]++;
            ja = w;
            m_last = w;
        end
    endtask

    task automatic drive(int pos[N]);
        for (int i = 0; i < N; i++) begin
            if (pos[i] < bq[i].size()) begin
                REQ[i] = 1'b1;
                REQ_WE[i] = bq[i][pos[i]].we;
                REQ_ADDR[i*AW +: AW] = bq[i][pos[i]].addr;
                REQ_WDATA[i*DW +: DW] = bq[i][pos[i]].data;
                REQ_WSTRB[i*4 +: 4] = bq[i][pos[i]].strb;
            end else REQ[i] = 1'b0;
        end
    endtask

    task automatic run_batch();
        int pos[N];
        int cyc = 0;
        bit done;
        model_batch();
        for (int i = 0; i < N; i++) pos[i] = 0;
        drive(pos);
        forever begin
            @(negedge ACLK);
            cyc++;
            for (int i = 0; i < N; i++) if (REQ_ACK[i]) pos[i]++;
            drive(pos);
            done = 1;
            for (int i = 0; i < N; i++) if (pos[i] < bq[i].size()) done = 0;
            if (done) break;
            if (cyc > 400) begin
                chk("batch_timeout", 64'(cyc), 64'(0));
                REQ = '0;
                break;
            end
        end
        for (int i = 0; i < N; i++) bq[i].delete();
        repeat (3) @(negedge ACLK);
    endtask

    function automatic op_t mk(bit we, logic [3:0] a, logic [31:0] d, logic [3:0] s);
        op_t o;
        o.we = we; o.addr = a; o.data = d; o.strb = s;
        return o;
    endfunction

    // Monitor: protocol rules and scoreboard, sampled on the falling edge
    logic p_rst = 0, p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
    logic [3:0]  p_awaddr, p_araddr;
    logic [31:0] p_wdata;

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge ACLK);
            if (ARESETn && p_rst) begin
                if (p_awv && !p_awr) begin
                    chk("awvalid_hold", 64'(axi.AWVALID), 64'(1));
                    chk("awaddr_stable", 64'(axi.AWADDR), 64'(p_awaddr));
                end
                if (p_wv && !p_wr) begin
                    chk("wvalid_hold", 64'(axi.WVALID), 64'(1));
                    chk("wdata_stable", 64'(axi.WDATA), 64'(p_wdata));
                end
                if (p_arv && !p_arr) begin
                    chk("arvalid_hold", 64'(axi.ARVALID), 64'(1));
                    chk("araddr_stable", 64'(axi.ARADDR), 64'(p_araddr));
                end
                if (axi.AWVALID && !p_awv && !p_wv)
                    chk("aw_w_rise_together", 64'(axi.WVALID), 64'(1));
                if (axi.BREADY)
                    chk("bready_after_aw_w", 64'({axi.AWVALID, axi.WVALID}), 64'(0));
            end
            if (REQ_ACK != '0) begin
                chk("ack_onehot", 64'($onehot(REQ_ACK)), 64'(1));
                if (expq.size() == 0) chk("ack_unexpected", 64'(REQ_ACK), 64'(0));
                else begin
                    e = expq.pop_front();
                    chk("ack_idx", 64'(REQ_ACK), 64'(N'(1) << e.idx));
                    if (!e.we) chk("rdata", 64'(REQ_RDATA), 64'(e.rd));
                end
            end
            p_rst = ARESETn;
            p_awv = axi.AWVALID; p_awr = axi.AWREADY; p_awaddr = axi.AWADDR;
            p_wv = axi.WVALID; p_wr = axi.WREADY; p_wdata = axi.WDATA;
            p_arv = axi.ARVALID; p_arr = axi.ARREADY; p_araddr = axi.ARADDR;
        end
    endtask

    task automatic main_seq();
        int n, cyc;
        ARESETn = 0;
        REQ = '0; REQ_WE = '0; REQ_ADDR = '0; REQ_WDATA = '0; REQ_WSTRB = '0;
        model_reset();
        repeat (3) @(negedge ACLK);
        chk("rst_ack", 64'(REQ_ACK), 64'(0));
        chk("rst_valids", 64'({axi.AWVALID, axi.WVALID, axi.ARVALID}), 64'(0));
        chk("rst_readys", 64'({axi.BREADY, axi.RREADY}), 64'(0));
        chk("rst_payload", 64'({axi.AWADDR, axi.WSTRB, axi.ARADDR}), 64'(0));
        chk("rst_rdata", 64'(REQ_RDATA), 64'(0));
        ARESETn = 1;
        repeat (2) @(negedge ACLK);

        bq[0].push_back(mk(1, 4'h4, 32'hDEADBEEF, 4'hF));
        run_batch();
        bq[1].push_back(mk(0, 4'h4, 32'h0, 4'h0));
        run_batch();

        bq[0].push_back(mk(1, 4'h8, 32'h12345678, 4'hF));
        bq[1].push_back(mk(0, 4'h8, 32'h0, 4'h0));
        run_batch();

        for (int i = 0; i < 4; i++) begin
            bq[0].push_back(mk(1, 4'(4 * i), 32'hA000_0000 + i, 4'hF));
            bq[1].push_back(mk(0, 4'(4 * i), 32'h0, 4'h0));
        end
        run_batch();

        aw_dly = 3; w_dly = 1;
        bq[0].push_back(mk(1, 4'h0, 32'h5A5A5A5A, 4'hF));
        run_batch();
        aw_dly = 0; w_dly = 0;

        bq[0].push_back(mk(1, 4'hC, 32'hFFFFFFFF, 4'hF));
        bq[0].push_back(mk(1, 4'hC, 32'h0000ABCD, 4'h3));
        bq[0].push_back(mk(0, 4'hC, 32'h0, 4'h0));
        run_batch();

        for (int it = 0; it < 30; it++) begin
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
            ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 2);
            for (int i = 0; i < N; i++) begin
                n = $urandom_range(0, 3);
                for (int k = 0; k < n; k++)
                    bq[i].push_back(mk(1'($urandom), 4'($urandom), $urandom, 4'($urandom)));
            end
            run_batch();
        end

        // Reset while waiting for read data: transaction abandoned, no ack
        ar_dly = 0; r_dly = 5;
        REQ = 2'b10; REQ_WE = '0; REQ_ADDR[AW +: AW] = 4'h4;
        cyc = 0;
        while (!axi.RREADY && cyc < 20) begin
            @(negedge ACLK);
            cyc++;
        end
        chk("reach_rdata", 64'(axi.RREADY), 64'(1));
        REQ = '0;
        ARESETn = 0;
        @(negedge ACLK);
        chk("midrst_rready", 64'(axi.RREADY), 64'(0));
        chk("midrst_arvalid", 64'(axi.ARVALID), 64'(0));
        chk("midrst_ack", 64'(REQ_ACK), 64'(0));
        chk("midrst_rdata", 64'(REQ_RDATA), 64'(0));
        ARESETn = 1;
        model_reset();
        r_dly = 0;
        repeat (6) @(negedge ACLK);
        bq[0].push_back(mk(0, 4'h4, 32'h0, 4'h0));
        bq[1].push_back(mk(0, 4'h8, 32'h0, 4'h0));
        run_batch();

        cyc = 0;
        while (expq.size() != 0 && cyc < 50) begin
            @(negedge ACLK);
            cyc++;
        end
        chk("scoreboard_drained", 64'(expq.size()), 64'(0));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    endtask

    initial begin
        fork
            monitor();
            main_seq();
        join
    end

endmodule
